// File: rtl/rename_map_table_pkg.sv
// rename_map_table_pkg: shared sizes, tag types and the rename output record
package rename_map_table_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 128;
    localparam int PT = $clog2(PHYS_REGS);
    typedef logic [4:0] arch_reg_t;
    typedef logic [PT-1:0] phys_reg_t;
    typedef struct packed {
        phys_reg_t prs1;
        phys_reg_t prs2;
        phys_reg_t prd;
        phys_reg_t old_prd;
    } rename_out_t;
endpackage

// File: rtl/rename_map_table_rat.sv
// rat_array: 32-entry register alias table with async reads, one write port and a bulk load
import rename_map_table_pkg::*;
module rat_array #(
    parameter int NR = 3
) (
    input  logic      clk,
    input  logic      rst,
    input  arch_reg_t raddr [NR],
    output phys_reg_t rdata [NR],
    input  logic      we,
    input  arch_reg_t waddr,
    input  phys_reg_t wdata,
    input  logic      load,
    input  phys_reg_t load_data [ARCH_REGS],
    output phys_reg_t map [ARCH_REGS]
);
    phys_reg_t mem [ARCH_REGS];
    // Identity mapping on reset; a write beats a bulk load on the same entry so a flush can fold in a commit; x0 is never written
    always_ff @(posedge clk) begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            if (!rst) mem[i] <= phys_reg_t'(i);
            else if (we && i != 0 && waddr == arch_reg_t'(i)) mem[i] <= wdata;
            else if (load) mem[i] <= load_data[i];
        end
    end
    // x0 reads are forced to tag 0 regardless of table contents
    always_comb begin
        for (int r = 0; r < NR; r++) rdata[r] = raddr[r] == '0 ? '0 : mem[raddr[r]];
    end
    assign map = mem;
endmodule

// File: rtl/rename_map_table.sv
// rename_map_table: single-issue rename with speculative/architectural RATs and flush recovery
import rename_map_table_pkg::*;
module rename_map_table (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [4:0]    in_rd,
    input  logic          in_rd_wen,
    input  logic [PT-1:0] fl_tag,
    input  logic          fl_empty,
    output logic          fl_r_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PT-1:0] out_prs1,
    output logic [PT-1:0] out_prs2,
    output logic [PT-1:0] out_prd,
    output logic [PT-1:0] out_old_prd,
    input  logic          commit_valid,
    input  logic [4:0]    commit_rd,
    input  logic [PT-1:0] commit_prd,
    input  logic          flush
);
    logic alloc, accept, commit_we;
    phys_reg_t spec_rd [3];
    phys_reg_t arch_rd_unused [2];
    phys_reg_t arch_map [ARCH_REGS];
    phys_reg_t spec_map_unused [ARCH_REGS];
    phys_reg_t zero_map [ARCH_REGS];
    rename_out_t out_q;
    assign alloc = in_rd_wen && in_rd != '0;
    assign in_ready = (!out_valid || out_ready) && !(alloc && fl_empty) && !flush;
    assign accept = in_valid && in_ready;
    assign fl_r_en = accept && alloc;
    assign commit_we = commit_valid && commit_rd != '0;
    assign zero_map = '{default: '0};
    rat_array #(.NR(3)) u_spec (
        .clk(clk),
        .rst(rst),
        .raddr('{in_rs1, in_rs2, in_rd}),
        .rdata(spec_rd),
        .we(flush ? commit_we : fl_r_en),
        .waddr(flush ? commit_rd : in_rd),
        .wdata(flush ? commit_prd : fl_tag),
        .load(flush),
        .load_data(arch_map),
        .map(spec_map_unused)
    );
    rat_array #(.NR(2)) u_arch (
        .clk(clk),
        .rst(rst),
        .raddr('{5'd0, 5'd0}),
        .rdata(arch_rd_unused),
        .we(commit_we),
        .waddr(commit_rd),
        .wdata(commit_prd),
        .load(1'b0),
        .load_data(zero_map),
        .map(arch_map)
    );
    // Output register: flush drops it, accept loads it, a stalled output holds, a drained output empties
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_q <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_q <= '{prs1: spec_rd[0], prs2: spec_rd[1], prd: alloc ? fl_tag : '0, old_prd: alloc ? spec_rd[2] : '0};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
    assign out_prs1 = out_q.prs1;
    assign out_prs2 = out_q.prs2;
    assign out_prd = out_q.prd;
    assign out_old_prd = out_q.old_prd;
endmodule

// File: tb/tb_rename_map_table.sv
// tb_rename_map_table: directed rename, stall, x0, empty free-list, commit/flush and reset checks
module tb_rename_map_table;
    logic clk = 0, rst = 0;
    logic in_valid = 0, in_ready, in_rd_wen = 0, fl_empty = 0, fl_r_en;
    logic [4:0] in_rs1 = 0, in_rs2 = 0, in_rd = 0, commit_rd = 0;
    logic [6:0] fl_tag = 0, commit_prd = 0, out_prs1, out_prs2, out_prd, out_old_prd;
    logic out_valid, out_ready = 1, commit_valid = 0, flush = 0;
    int n_cmp = 0, n_err = 0;
    always #5 clk = ~clk;
    rename_map_table dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .fl_tag(fl_tag), .fl_empty(fl_empty), .fl_r_en(fl_r_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_prs1(out_prs1), .out_prs2(out_prs2),
        .out_prd(out_prd), .out_old_prd(out_old_prd), .commit_valid(commit_valid),
        .commit_rd(commit_rd), .commit_prd(commit_prd), .flush(flush)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic wen, input logic [6:0] tag);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wen = wen; fl_tag = tag;
    endtask
    task automatic chk_out(input string tag, input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] pd, input logic [6:0] op);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_prs1"}, out_prs1, p1);
        chk({tag, "_prs2"}, out_prs2, p2);
        chk({tag, "_prd"}, out_prd, pd);
        chk({tag, "_old"}, out_old_prd, op);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_prd", out_prd, 0);
        chk("rst_old", out_old_prd, 0);
        chk("rst_pop", fl_r_en, 0);
        rst = 1;
        @(negedge clk);
        drive(1, 2, 3, 1, 32);
        #1 chk("add_pop", fl_r_en, 1);
        chk("add_ready", in_ready, 1);
        @(negedge clk);
        chk_out("add", 1, 2, 32, 3);
        drive(3, 3, 4, 1, 33);
        #1 chk("sub_pop", fl_r_en, 1);
        @(negedge clk);
        chk_out("sub", 32, 32, 33, 4);
        drive(0, 4, 0, 1, 34);
        #1 chk("x0_pop", fl_r_en, 0);
        @(negedge clk);
        chk_out("x0", 0, 33, 0, 0);
        drive(7, 0, 7, 1, 35);
        fl_empty = 1;
        #1 chk("empty_ready", in_ready, 0);
        chk("empty_pop", fl_r_en, 0);
        @(negedge clk);
        chk("empty_valid", out_valid, 0);
        fl_empty = 0;
        #1 chk("refill_pop", fl_r_en, 1);
        @(negedge clk);
        chk_out("refill", 7, 0, 35, 7);
        out_ready = 0;
        drive(7, 4, 8, 1, 36);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", in_ready, 0);
            chk("stall_pop", fl_r_en, 0);
            @(negedge clk);
            chk_out("stall", 7, 0, 35, 7);
        end
        out_ready = 1;
        #1 chk("unstall_pop", fl_r_en, 1);
        @(negedge clk);
        chk_out("unstall", 35, 33, 36, 8);
        drive(5, 0, 5, 1, 40);
        @(negedge clk);
        chk_out("x5a", 5, 0, 40, 5);
        drive(5, 0, 5, 1, 41);
        commit_valid = 1; commit_rd = 5; commit_prd = 40;
        @(negedge clk);
        chk_out("x5b", 40, 0, 41, 40);
        drive(9, 9, 9, 1, 42);
        commit_rd = 6; commit_prd = 50; flush = 1;
        #1 chk("flush_ready", in_ready, 0);
        chk("flush_pop", fl_r_en, 0);
        @(negedge clk);
        chk("flush_valid", out_valid, 0);
        flush = 0; commit_valid = 0;
        drive(5, 6, 5, 1, 43);
        #1 chk("resume_pop", fl_r_en, 1);
        @(negedge clk);
        chk_out("resume", 40, 50, 43, 40);
        drive(9, 5, 9, 1, 44);
        @(negedge clk);
        chk_out("x9", 9, 43, 44, 9);
        rst = 0; flush = 1; commit_valid = 1; commit_rd = 5; commit_prd = 99;
        drive(5, 5, 5, 1, 45);
        @(negedge clk);
        chk("rst2_valid", out_valid, 0);
        chk("rst2_prd", out_prd, 0);
        rst = 1; flush = 0; commit_valid = 0;
        drive(5, 6, 0, 0, 46);
        #1 chk("rst2_pop", fl_r_en, 0);
        @(negedge clk);
        chk_out("rst2", 5, 6, 0, 0);
        in_valid = 0;
        @(negedge clk);
        chk("drain_valid", out_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
